// File: rtl/vga_pixel_fetch.sv
// rtl/vga_pixel_fetch.sv - RGB565 prefetch FIFO feeding vga2dvid pixel inputs
// Requests words ahead of the raster, pops one per active pixel, flushes on vsync rise.
module vga_pixel_fetch #(
  parameter int unsigned C_addr_bits       = 20,
  parameter int unsigned C_base_addr       = 0,
  parameter int unsigned C_fifo_depth      = 16,
  parameter int unsigned C_max_outstanding = 4,
  parameter logic [23:0] C_underflow_rgb   = 24'hFF00FF
) (
  input  logic                   clk_pixel,
  input  logic                   reset,
  input  logic                   in_hsync,
  input  logic                   in_vsync,
  input  logic                   in_blank,
  output logic                   mem_req,
  output logic [C_addr_bits-1:0] mem_addr,
  input  logic                   mem_ack,
  input  logic                   mem_valid,
  input  logic [15:0]            mem_data,
  output logic [7:0]             vga_r,
  output logic [7:0]             vga_g,
  output logic [7:0]             vga_b,
  output logic                   vga_hsync,
  output logic                   vga_vsync,
  output logic                   vga_blank,
  output logic                   underflow
);

  localparam int AW = $clog2(C_fifo_depth);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(C_max_outstanding + 1);
  localparam int SW = CW + OW;
  localparam logic [SW-1:0]          DEPTH_S = SW'(C_fifo_depth);
  localparam logic [OW-1:0]          MAXO    = OW'(C_max_outstanding);
  localparam logic [C_addr_bits-1:0] BASE    = C_addr_bits'(C_base_addr);

  logic [15:0]            fifo_q [C_fifo_depth];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [OW-1:0]          out_q, out_d, discard_q, discard_d;
  logic [C_addr_bits-1:0] addr_q, addr_d;
  logic                   run_q;
  logic [7:0]             r_q, g_q, b_q;
  logic                   hsync_q, vsync_q, blank_q, und_q;

  logic                   flush, req, accept, pop, wr;
  logic [SW-1:0]          sum;
  logic [15:0]            pop_word;

  always_comb begin
    flush    = in_vsync & ~vsync_q;
    sum      = SW'(count_q) + SW'(out_q);
    // Withdrawn combinationally in the flush cycle so no stale address is ever acked.
    req      = run_q & ~flush & (sum < DEPTH_S) & (out_q < MAXO);
    accept   = req & mem_ack;
    pop      = ~in_blank & (count_q != '0);
    wr       = mem_valid & ~flush & (discard_q == '0);
    pop_word = fifo_q[rd_ptr_q];

    out_d = out_q + OW'(accept);
    if (mem_valid && (out_q != '0)) out_d = out_d - OW'(1);

    discard_d = discard_q;
    if (flush) discard_d = out_d;
    else if (mem_valid && (discard_q != '0)) discard_d = discard_q - OW'(1);

    count_d  = flush ? '0 : count_q + CW'(wr) - CW'(pop);
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(wr);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);

    addr_d = addr_q;
    if (flush) addr_d = BASE;
    else if (accept) addr_d = addr_q + 1'b1;
  end

  always_ff @(posedge clk_pixel) begin
    if (wr) fifo_q[wr_ptr_q] <= mem_data;
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      run_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      out_q     <= '0;
      discard_q <= '0;
      addr_q    <= BASE;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
      blank_q   <= 1'b1;
      und_q     <= 1'b0;
    end else begin
      run_q     <= 1'b1;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      out_q     <= out_d;
      discard_q <= discard_d;
      addr_q    <= addr_d;
      hsync_q   <= in_hsync;
      vsync_q   <= in_vsync;
      blank_q   <= in_blank;
      if (in_blank) begin
        r_q <= '0;
        g_q <= '0;
        b_q <= '0;
      end else if (pop) begin
        r_q <= {pop_word[15:11], pop_word[15:13]};
        g_q <= {pop_word[10:5], pop_word[10:9]};
        b_q <= {pop_word[4:0], pop_word[4:2]};
      end else begin
        r_q   <= C_underflow_rgb[23:16];
        g_q   <= C_underflow_rgb[15:8];
        b_q   <= C_underflow_rgb[7:0];
        und_q <= 1'b1;
      end
    end
  end

  assign mem_req   = req;
  assign mem_addr  = addr_q;
  assign vga_r     = r_q;
  assign vga_g     = g_q;
  assign vga_b     = b_q;
  assign vga_hsync = hsync_q;
  assign vga_vsync = vsync_q;
  assign vga_blank = blank_q;
  assign underflow = und_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb/tb_vga_pixel_fetch.sv - scoreboard bench for vga_pixel_fetch
// Memory returns 3 cycles after accept; expected video is queued per cycle and checked by a monitor.
module tb_vga_pixel_fetch;

  logic        clk_pixel = 1'b0;
  logic        reset = 1'b1, in_hsync = 1'b0, in_vsync = 1'b0, in_blank = 1'b1;
  logic        mem_req, mem_ack, mem_valid = 1'b0;
  logic [19:0] mem_addr;
  logic [15:0] mem_data = 16'h0;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hsync, vga_vsync, vga_blank, underflow;

  logic ack_en = 1'b0, freeze = 1'b0;
  assign mem_ack = mem_req & ack_en;

  vga_pixel_fetch dut (
    .clk_pixel(clk_pixel), .reset(reset),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_blank(in_blank),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_valid(mem_valid), .mem_data(mem_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank(vga_blank),
    .underflow(underflow)
  );

  always #5 clk_pixel = ~clk_pixel;

  int unsigned cyc = 0;
  always @(posedge clk_pixel) cyc <= cyc + 1;

  int passed = 0, total = 0;

  typedef struct { int unsigned cyc; logic [23:0] rgb; logic hs, vs, bl, und; } exp_t;
  typedef struct { int unsigned due; logic [19:0] addr; } pend_t;
  exp_t        exp_q[$];
  pend_t       pend_q[$];
  logic [15:0] mq[$];
  int          m_out = 0, m_disc = 0;
  logic [19:0] m_addr = '0;
  logic        m_und = 1'b0, m_vs_prev = 1'b0, rst_prev = 1'b0;
  logic        ovr_en = 1'b0;
  logic [23:0] ovr_rgb = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [15:0] word_of(input logic [19:0] a);
    case (a)
      20'd0:   return 16'hFFFF;
      20'd1:   return 16'h0000;
      20'd2:   return 16'hF800;
      20'd3:   return 16'h07E0;
      20'd4:   return 16'h001F;
      default: return a[15:0];
    endcase
  endfunction

  function automatic logic [23:0] expand(input logic [15:0] w);
    return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
  endfunction

  task automatic tick(input logic rst, input logic hs, input logic vs, input logic bl);
    exp_t        e;
    logic        flush, acc;
    logic [23:0] rgb;
    reset = rst; in_hsync = hs; in_vsync = vs; in_blank = bl;
    if (!rst && !freeze && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      mem_valid = 1'b1;
      mem_data  = word_of(pend_q[0].addr);
    end else begin
      mem_valid = 1'b0;
      mem_data  = 16'h0;
    end
    #1;
    if (rst) begin
      if (rst_prev) begin
        check("rst_mem_req", 32'(mem_req), 32'(0));
        check("rst_mem_addr", 32'(mem_addr), 32'(0));
      end
      pend_q.delete(); mq.delete();
      m_out = 0; m_disc = 0; m_addr = '0; m_und = 1'b0; m_vs_prev = 1'b0;
      e = '{cyc + 1, 24'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    end else begin
      flush = vs & ~m_vs_prev;
      if (flush) check("flush_req_withdrawn", 32'(mem_req), 32'(0));
      acc = mem_req & mem_ack;
      if (acc) begin
        check("req_addr", 32'(mem_addr), 32'(m_addr));
        pend_q.push_back('{cyc + 3, mem_addr});
        m_addr = m_addr + 1'b1;
      end
      if (bl) rgb = 24'h0;
      else if (mq.size() > 0) rgb = expand(mq.pop_front());
      else begin
        rgb = 24'hFF00FF;
        m_und = 1'b1;
      end
      if (ovr_en) begin
        rgb = ovr_rgb;
        ovr_en = 1'b0;
      end
      if (mem_valid) begin
        pend_q.delete(0);
        m_out--;
        if (!flush) begin
          if (m_disc > 0) m_disc--;
          else mq.push_back(mem_data);
        end
      end
      if (flush) begin
        mq.delete();
        m_disc = m_out;
        m_addr = '0;
      end
      if (acc) m_out++;
      check("fifo_no_overflow", 32'(mq.size() <= 16), 32'(1));
      check("outstanding_limit", 32'(m_out <= 4 && (mq.size() + m_out) <= 16), 32'(1));
      m_vs_prev = vs;
      e = '{cyc + 1, rgb, hs, vs, bl, m_und};
    end
    exp_q.push_back(e);
    rst_prev = rst;
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic pix(input logic [23:0] rgb);
    ovr_en = 1'b1;
    ovr_rgb = rgb;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk_pixel) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      check("video_rgb", 32'({vga_r, vga_g, vga_b}), 32'(e.rgb));
      check("video_sync", 32'({vga_hsync, vga_vsync, vga_blank}), 32'({e.hs, e.vs, e.bl}));
      check("underflow", 32'(underflow), 32'(e.und));
    end
  end

  initial begin
    logic [31:0] r;
    @(posedge clk_pixel); #1;
    repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b1);

    ack_en = 1'b1;
    repeat (40) tick(1'b0, 1'b0, 1'b0, 1'b1);
    check("full_fifo_no_req", 32'(mem_req), 32'(0));

    pix(24'hFFFFFF); pix(24'h000000); pix(24'hFF0000); pix(24'h00FF00); pix(24'h0000FF);
    repeat (59) tick(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (8) tick(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (32) tick(1'b0, 1'b0, 1'b0, 1'b1);

    ack_en = 1'b0;
    repeat (16) tick(1'b0, 1'b0, 1'b0, 1'b0);
    pix(24'hFF00FF);
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (10) tick(1'b0, 1'b0, 1'b0, 1'b1);
    ack_en = 1'b1;
    repeat (30) tick(1'b0, 1'b0, 1'b0, 1'b1);

    ack_en = 1'b0;
    repeat (16) tick(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b1);
    freeze = 1'b1; ack_en = 1'b1;
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b1);
    ack_en = 1'b0;
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    check("addr_restart", 32'(mem_addr), 32'(0));
    check("req_resume", 32'(mem_req), 32'(1));
    freeze = 1'b0; ack_en = 1'b1;
    repeat (3) tick(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (40) tick(1'b0, 1'b0, 1'b0, 1'b1);
    pix(24'hFFFFFF); pix(24'h000000);
    repeat (30) tick(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (10) tick(1'b0, 1'b0, 1'b0, 1'b1);

    repeat (200) begin
      r = $urandom;
      tick(1'b0, r[0], r[1] & r[2], r[3] | r[4]);
    end
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (20) tick(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (10) tick(1'b0, 1'b0, 1'b0, 1'b0);

    repeat (2) @(negedge clk_pixel);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
